instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   Front-end fetch stage: owns the PC and issues one instruction-memory request at a time.
//   Buffers returned words with their PC, and presents them to decode (immgen and control)
//   over a valid/ready handshake. Accepts redirects from the branch/jump resolution logic.
//   Squashes stale in-flight fetches after a redirect.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC fetched first after reset release
//   BUF_DEPTH   2              instruction buffer entries; power of two, >=2
// PORTS
//   i_clk            in   1   clock, rising edge
//   i_rst_n          in   1   asynchronous active-low reset
//   o_imem_req       out  1   fetch request valid
//   o_imem_addr      out  32  fetch byte address (word aligned)
//   i_imem_ready     in   1   memory accepts request this cycle (req && ready = accept)
//   i_imem_rvalid    in   1   read data valid; at earliest 1 cycle after accept
//   i_imem_rdata     in   32  instruction word
//   o_instr_valid    out  1   o_instr/o_instr_pc hold a valid entry (buffer head)
//   o_instr          out  32  instruction to decode/immgen
//   o_instr_pc       out  32  PC of o_instr
//   i_instr_ready    in   1   decode consumes head this cycle
//   i_redirect       in   1   taken branch/jump: flush and refetch
//   i_redirect_pc    in   32  redirect target
//   o_fetch_err      out  1   sticky: misaligned redirect target seen
// BEHAVIOUR
// - Reset (async assert, sync release): pc=RESET_PC, buffer empty, state S_REQ.
//   o_imem_req=0 and o_instr_valid=0 while reset is asserted. Also o_fetch_err=0,
//   o_imem_addr=RESET_PC, o_instr=0, o_instr_pc=0.
// - States: S_REQ, S_WAIT, S_DROP, S_HALT. At most one outstanding request.
// - S_REQ: o_imem_req = (count < BUF_DEPTH); o_imem_addr = pc.
//   On accept: latch req_pc=pc, pc<=pc+4 (mod 2^32), go to S_WAIT.
//   i_imem_rvalid is ignored in S_REQ.
// - S_WAIT: o_imem_req=0. On rvalid: push {rdata, req_pc}, go to S_REQ.
//   A slot is guaranteed, because count < BUF_DEPTH at issue and there is only one outstanding request.
// - S_DROP: o_imem_req=0. On rvalid: discard the data, go to S_REQ.
// - Output: o_instr_valid = (count!=0); head entry drives o_instr/o_instr_pc.
//   Pop when valid && i_instr_ready. Push and pop may occur in the same cycle (count unchanged).
//   Read/write pointers wrap modulo BUF_DEPTH.
// - Latency: accept at cycle N, rvalid at cycle M (M>=N+1), o_instr_valid at M+1 (registered).
//   No combinational path from i_imem_* to o_instr_*.
// - Redirect (highest priority, any state except S_HALT):
//   - Buffer flushed (count=0; a same-cycle pop or push is void). pc<=i_redirect_pc.
//   - S_WAIT without rvalid this cycle -> S_DROP.
//   - S_WAIT with rvalid this cycle -> data dropped, go to S_REQ.
//   - S_REQ with accept this cycle -> accepted fetch is stale, go to S_DROP; pc not incremented.
//   - S_DROP -> stay in S_DROP with the new pc.
//   - S_REQ without accept -> stay in S_REQ; next o_imem_addr = new target.
// - Misaligned redirect (i_redirect_pc[1:0]!=0):
//   - o_fetch_err<=1 (sticky), buffer flushed, go to S_HALT.
//   - S_HALT: req=0, valid=0, rvalid ignored. Exit only via reset.
// - Reset mid-transaction: all state cleared. Memory must not deliver the pre-reset response afterwards.
// TESTING
// 1. RESET_PC=0x1000, memory latency 1, word 0x00500093 at 0x1000.
//    -> first accept addr=0x1000; o_instr=0x00500093, o_instr_pc=0x1000 two cycles after accept.
// 2. i_instr_ready=0, streaming fetch.
//    -> after 2 entries o_imem_req=0. Raise ready -> pops pc 0x1000 then 0x1004; next req addr 0x1008.
// 3. Redirect to 0x2000 while 0x1008 is in flight (S_WAIT).
//    -> 0x1008 data discarded; next req addr 0x2000; first valid o_instr_pc=0x2000.
// 4. Redirect to 0x2000 in the same cycle as rvalid, and separately in the same cycle as accept.
//    -> no stale entry appears; next delivered PC 0x2000.
// 5. Redirect to 0x2002.
//    -> o_fetch_err=1 next cycle; req=0 and valid=0 for 20 cycles; cleared only by i_rst_n=0.
// 6. Redirect to 0xFFFF_FFFC.
//    -> instr with pc 0xFFFF_FFFC delivered; next req addr 0x0000_0000.
// 7. Simultaneous push and pop with buffer full (BUF_DEPTH=2).
//    -> count stays 2; FIFO order preserved across pointer wrap.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch front end: owns the PC, keeps one memory request in flight,
// buffers returned words with their PC and hands them to decode over valid/ready.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    input  logic        i_instr_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_fetch_err
);
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HALT} state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        req_pc_q, req_pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;

    logic [31:0]        buf_instr [BUF_DEPTH];
    logic [31:0]        buf_pc    [BUF_DEPTH];

    logic               accept;
    logic               push;
    logic               pop;
    logic               redirect_ok;
    logic               redirect_bad;
    logic               buf_full;

    assign buf_full = (count_q == CNT_W'(BUF_DEPTH));

    // Request is masked while reset is held so nothing is issued before release.
    assign o_imem_req    = i_rst_n && (state_q == S_REQ) && !buf_full;
    assign o_imem_addr   = pc_q;
    assign o_instr_valid = (count_q != '0);
    assign o_instr       = o_instr_valid ? buf_instr[rd_ptr_q] : '0;
    assign o_instr_pc    = o_instr_valid ? buf_pc[rd_ptr_q]    : '0;
    assign o_fetch_err   = err_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        err_d        = err_q;
        accept       = o_imem_req && i_imem_ready;
        push         = 1'b0;
        pop          = o_instr_valid && i_instr_ready;
        redirect_ok  = 1'b0;
        redirect_bad = 1'b0;

        if (i_redirect && (state_q != S_HALT)) begin
            if (i_redirect_pc[1:0] != 2'b00) begin
                redirect_bad = 1'b1;
            end else begin
                redirect_ok = 1'b1;
            end
        end

        case (state_q)
            S_REQ: begin
                if (accept) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    push    = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (i_imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            S_HALT: begin
                pop = 1'b0;
            end
        endcase

        if (redirect_ok) begin
            pc_d = i_redirect_pc;
            case (state_q)
                S_REQ:   state_d = accept ? S_DROP : S_REQ;
                S_WAIT:  state_d = i_imem_rvalid ? S_REQ : S_DROP;
                // A response landing in the same cycle is the stale one being waited for.
                S_DROP:  state_d = i_imem_rvalid ? S_REQ : S_DROP;
                default: state_d = state_q;
            endcase
        end

        if (redirect_bad) begin
            err_d   = 1'b1;
            state_d = S_HALT;
        end

        if (redirect_ok || redirect_bad) begin
            push     = 1'b0;
            pop      = 1'b0;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            buf_instr[wr_ptr_q] <= i_imem_rdata;
            buf_pc[wr_ptr_q]    <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic, checked against
// a program-order model (expected fetch PC, buffered PC queue, one-outstanding memory).
module tb_instr_fetch;
    localparam logic [31:0] RPC   = 32'h0000_1000;
    localparam int          DEPTH = 2;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready = 1'b0;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_instr_ready = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_fetch_err;

    instr_fetch #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ready(i_imem_ready), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .o_instr_valid(o_instr_valid), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
        .i_instr_ready(i_instr_ready), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_fetch_err(o_fetch_err)
    );

    always #5 i_clk = ~i_clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic        mem_busy = 1'b0;
    logic        mem_live = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_wait = 0;
    int          lat = 1;
    bit          rand_lat = 1'b0;
    int          spurious_pct = 0;
    logic [31:0] fetch_pc = RPC;
    logic        halted = 1'b0;
    int          delivered = 0;
    logic        s_req, s_valid, s_err;
    logic [31:0] s_addr, s_instr, s_pc;
    logic [31:0] last_acc_addr = '0;
    logic        found;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory response, sample and check outputs, advance the model.
    task automatic tick();
        logic rv, exp_req, acc, pop, redir, do_push;
        rv = mem_busy && (mem_wait == 0);
        i_imem_rvalid = rv || (!mem_busy && ($urandom_range(99) < 32'(spurious_pct)));
        i_imem_rdata  = rv ? word_at(mem_addr) : $urandom;
        #1;
        s_req = o_imem_req; s_addr = o_imem_addr; s_valid = o_instr_valid;
        s_instr = o_instr; s_pc = o_instr_pc; s_err = o_fetch_err;
        exp_req = !halted && !mem_busy && (exp_q.size() < DEPTH);
        chk("req", 32'(s_req), 32'(exp_req));
        chk("valid", 32'(s_valid), 32'(exp_q.size() != 0));
        chk("err", 32'(s_err), 32'(halted));
        if (exp_q.size() != 0) begin
            chk("head_pc", s_pc, exp_q[0]);
            chk("head_instr", s_instr, word_at(exp_q[0]));
        end
        if (exp_req) chk("req_addr", s_addr, fetch_pc);

        acc     = exp_req && i_imem_ready;
        pop     = (exp_q.size() != 0) && i_instr_ready;
        redir   = i_redirect && !halted;
        do_push = 1'b0;
        if (rv) begin
            do_push  = mem_live && !redir && !halted;
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            mem_wait--;
        end
        if (pop && !redir) begin
            void'(exp_q.pop_front());
            delivered++;
        end
        if (do_push) exp_q.push_back(mem_addr);
        if (acc) begin
            mem_busy      = 1'b1;
            mem_live      = 1'b1;
            mem_addr      = fetch_pc;
            mem_wait      = rand_lat ? int'($urandom_range(2)) : lat - 1;
            last_acc_addr = fetch_pc;
            fetch_pc      = fetch_pc + 32'd4;
        end
        if (redir) begin
            exp_q.delete();
            mem_live = 1'b0;
            if (i_redirect_pc[1:0] != 2'b00) halted = 1'b1;
            else fetch_pc = i_redirect_pc;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        i_rst_n = 1'b0;
        i_imem_ready = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
        i_instr_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
        #1;
        chk("rst_req", 32'(o_imem_req), 32'd0);
        chk("rst_valid", 32'(o_instr_valid), 32'd0);
        chk("rst_err", 32'(o_fetch_err), 32'd0);
        chk("rst_addr", o_imem_addr, RPC);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_pc", o_instr_pc, 32'd0);
        exp_q.delete();
        mem_busy = 1'b0; mem_live = 1'b0; mem_wait = 0;
        halted = 1'b0; fetch_pc = RPC;
        repeat (cycles) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int max_cycles, output logic got);
        got = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (s_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("wait_valid_timeout", 32'(got), 32'd1);
    endtask

    task automatic redirect_once(input logic [31:0] target);
        i_redirect = 1'b1;
        i_redirect_pc = target;
        tick();
        i_redirect = 1'b0;
    endtask

    initial begin
        @(posedge i_clk);
        #1;
        do_reset(3);

        // First fetch from reset PC, latency 1: instruction visible two cycles after accept.
        lat = 1; i_imem_ready = 1'b1; i_instr_ready = 1'b0;
        tick();
        chk("t1_acc_addr", last_acc_addr, 32'h0000_1000);
        tick();
        tick();
        chk("t1_valid", 32'(s_valid), 32'd1);
        chk("t1_instr", s_instr, 32'h0050_0093);
        chk("t1_pc", s_pc, 32'h0000_1000);

        // Decode stalled: buffer fills and requests stop; then drain in order.
        repeat (5) tick();
        chk("t2_req_full", 32'(s_req), 32'd0);
        lat = 3; i_instr_ready = 1'b1;
        tick();
        chk("t2_pop0", s_pc, 32'h0000_1000);
        tick();
        chk("t2_pop1", s_pc, 32'h0000_1004);
        chk("t2_next_req", 32'(s_req), 32'd1);
        chk("t2_next_addr", s_addr, 32'h0000_1008);

        // Redirect while 0x1008 is outstanding.
        redirect_once(32'h0000_2000);
        wait_valid(40, found);
        chk("t3_pc", s_pc, 32'h0000_2000);

        // Redirect coinciding with rvalid.
        lat = 2;
        for (int i = 0; i < 20; i++) begin
            if (mem_busy && mem_wait == 0) break;
            tick();
        end
        chk("t4a_sync", 32'(mem_busy && mem_wait == 0), 32'd1);
        redirect_once(32'h0000_2000);
        wait_valid(40, found);
        chk("t4a_pc", s_pc, 32'h0000_2000);

        // Redirect coinciding with accept.
        for (int i = 0; i < 20; i++) begin
            if (!mem_busy && exp_q.size() < DEPTH) break;
            tick();
        end
        chk("t4b_sync", 32'(!mem_busy && exp_q.size() < DEPTH), 32'd1);
        redirect_once(32'h0000_2000);
        wait_valid(40, found);
        chk("t4b_pc", s_pc, 32'h0000_2000);

        // PC wraps past the top of the address space.
        redirect_once(32'hFFFF_FFFC);
        wait_valid(40, found);
        chk("t6_pc", s_pc, 32'hFFFF_FFFC);
        wait_valid(40, found);
        chk("t6_wrap_pc", s_pc, 32'h0000_0000);

        // Misaligned target halts fetch until reset.
        redirect_once(32'h0000_2002);
        tick();
        chk("t5_err", 32'(s_err), 32'd1);
        for (int i = 0; i < 20; i++) begin
            i_imem_ready = 1'($urandom_range(1));
            tick();
            chk("t5_req_halt", 32'(s_req), 32'd0);
            chk("t5_valid_halt", 32'(s_valid), 32'd0);
        end
        do_reset(2);
        tick();
        chk("t5_err_cleared", 32'(s_err), 32'd0);

        // Randomized traffic; each phase ends with a reset that may land mid-transaction.
        rand_lat = 1'b1;
        spurious_pct = 5;
        for (int ph = 0; ph < 6; ph++) begin
            delivered = 0;
            for (int c = 0; c < 300; c++) begin
                i_imem_ready  = ($urandom_range(99) < 70);
                i_instr_ready = ($urandom_range(99) < 50);
                i_redirect    = ($urandom_range(99) < 4);
                case ($urandom_range(9))
                    0:       i_redirect_pc = 32'hFFFF_FFF8;
                    default: i_redirect_pc = 32'h0000_3000 + {22'd0, 8'($urandom_range(255)), 2'b00};
                endcase
                if (ph >= 4 && c > 200 && $urandom_range(99) < 2) begin
                    i_redirect    = 1'b1;
                    i_redirect_pc = 32'h0000_3001;
                end
                tick();
            end
            chk("rand_progress", 32'(delivered > 0), 32'd1);
            do_reset(1 + int'($urandom_range(2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
